// File: rtl/config_seq.sv
// Configuration sequencer: boots the register bank with defaults, then round-robin
// arbitrates host/debug writes onto one write port. Boot is built only with CONFIG_SEQ_BOOT_EN.
module config_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_req,
  input  logic [1:0] host_addr,
  input  logic [1:0] host_data,
  output logic       host_gnt,
  input  logic       dbg_req,
  input  logic [1:0] dbg_addr,
  input  logic [1:0] dbg_data,
  output logic       dbg_gnt,
  output logic [1:0] config_addr,
  output logic [1:0] config_data,
  output logic       config_en,
  output logic       boot_done
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ARB   = 2'd1,
    WRITE = 2'd2
  } state_t;

`ifdef CONFIG_SEQ_BOOT_EN
  localparam logic [1:0] CH0_REG_ADDR    = 2'h0;
  localparam logic [1:0] CH1_REG_ADDR    = 2'h1;
  localparam logic [1:0] CH2_REG_ADDR    = 2'h2;
  localparam logic [1:0] CRC_EN_REG_ADDR = 2'h3;
  localparam logic [1:0] CH0_DEFAULT     = 2'h0;
  localparam logic [1:0] CH1_DEFAULT     = 2'h1;
  localparam logic [1:0] CH2_DEFAULT     = 2'h2;
  localparam logic       CRC_EN_DEFAULT  = 1'b0;
  localparam state_t     RESET_STATE     = BOOT;

  logic [1:0] bcnt_q, bcnt_d;
`else
  localparam state_t     RESET_STATE     = ARB;
`endif

  state_t     state_q, state_d;
  logic       ptr_dbg_q, ptr_dbg_d;   // 1: debug has priority on a tie
  logic       win_dbg_q, win_dbg_d;   // winner of the write in flight
  logic       host_gnt_q, host_gnt_d;
  logic       dbg_gnt_q, dbg_gnt_d;
  logic       config_en_q, config_en_d;
  logic [1:0] config_addr_q, config_addr_d;
  logic [1:0] config_data_q, config_data_d;
  logic       boot_done_q, boot_done_d;

  always_comb begin
    state_d       = state_q;
    ptr_dbg_d     = ptr_dbg_q;
    win_dbg_d     = win_dbg_q;
    host_gnt_d    = 1'b0;
    dbg_gnt_d     = 1'b0;
    config_en_d   = 1'b0;
    config_addr_d = config_addr_q;
    config_data_d = config_data_q;
    boot_done_d   = boot_done_q;
`ifdef CONFIG_SEQ_BOOT_EN
    bcnt_d        = bcnt_q;
`endif

    case (state_q)
      BOOT: begin
`ifdef CONFIG_SEQ_BOOT_EN
        config_en_d = 1'b1;
        bcnt_d      = bcnt_q + 2'd1;
        case (bcnt_q)
          2'd0: begin config_addr_d = CH0_REG_ADDR;    config_data_d = CH0_DEFAULT; end
          2'd1: begin config_addr_d = CH1_REG_ADDR;    config_data_d = CH1_DEFAULT; end
          2'd2: begin config_addr_d = CH2_REG_ADDR;    config_data_d = CH2_DEFAULT; end
          default: begin
            config_addr_d = CRC_EN_REG_ADDR;
            config_data_d = {1'b0, CRC_EN_DEFAULT};
            state_d       = ARB;
          end
        endcase
`else
        state_d = ARB;
`endif
      end

      ARB: begin
        boot_done_d = 1'b1;
        if (host_req && (!dbg_req || !ptr_dbg_q)) begin
          state_d       = WRITE;
          win_dbg_d     = 1'b0;
          host_gnt_d    = 1'b1;
          config_en_d   = 1'b1;
          config_addr_d = host_addr;
          config_data_d = host_data;
        end else if (dbg_req) begin
          state_d       = WRITE;
          win_dbg_d     = 1'b1;
          dbg_gnt_d     = 1'b1;
          config_en_d   = 1'b1;
          config_addr_d = dbg_addr;
          config_data_d = dbg_data;
        end
      end

      WRITE: begin
        // Requests are not sampled here; the requester reacts to gnt first.
        state_d   = ARB;
        ptr_dbg_d = ~win_dbg_q;
      end

      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      ptr_dbg_q     <= 1'b0;
      win_dbg_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      config_en_q   <= 1'b0;
      config_addr_q <= 2'd0;
      config_data_q <= 2'd0;
      boot_done_q   <= 1'b0;
`ifdef CONFIG_SEQ_BOOT_EN
      bcnt_q        <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_dbg_q     <= ptr_dbg_d;
      win_dbg_q     <= win_dbg_d;
      host_gnt_q    <= host_gnt_d;
      dbg_gnt_q     <= dbg_gnt_d;
      config_en_q   <= config_en_d;
      config_addr_q <= config_addr_d;
      config_data_q <= config_data_d;
      boot_done_q   <= boot_done_d;
`ifdef CONFIG_SEQ_BOOT_EN
      bcnt_q        <= bcnt_d;
`endif
    end
  end

  assign host_gnt    = host_gnt_q;
  assign dbg_gnt     = dbg_gnt_q;
  assign config_en   = config_en_q;
  assign config_addr = config_addr_q;
  assign config_data = config_data_q;
  assign boot_done   = boot_done_q;

endmodule
